mesh_input_unit: RTL
====================

# mesh_input_unit

Per-port input buffer for a MESH router, sitting on the request side of the router's switch controller. It accepts flits from the upstream router under valid/enable flow control and drives the enable back upstream. It computes an XY route for the head flit and issues a one-hot output-port request to the switch controller. On grant it presents the head flit to the crossbar and pops it.

## Interface
- `DATA_W`, 32: flit width. Destination X is `i_data[DATA_W-1 -: X_W]`; destination Y sits immediately below it.
- `X_W`, 2: X coordinate width.
- `Y_W`, 2: Y coordinate width.
- `LOCAL_X`, 0: this router's X coordinate.
- `LOCAL_Y`, 0: this router's Y coordinate.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `M`, 5: output ports, index order [c,n,e,s,w].

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_data`  in  DATA_W  flit from upstream.
- `i_data_val`  in  1  flit valid.
- `o_en`  out  1  enable to upstream; high means a flit may be sent this cycle.
- `o_output_req`  out  [0:M-1]  one-hot output request for the head flit; feeds that switch controller input's request word.
- `i_grant`  in  1  grant for this input: OR of this input's bit across all output grant words.
- `o_data`  out  DATA_W  head flit to the crossbar.
- `o_overflow`  out  1  sticky error flag; present only with the macro (see Configuration).

## Operation
- Circular FIFO with read pointer, write pointer and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- `o_en = (count != DEPTH)`. It is derived from registers only, with no combinational path from `i_grant`.
- Push when `i_data_val && o_en`. A valid flit arriving while `o_en` is low is dropped and the FIFO is unchanged.
- Pop when `i_grant && count != 0`. A grant while empty is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any count from 1 to DEPTH-1.
- `o_data` is the entry at the read pointer, and is meaningful only while `count != 0`.
- Route, computed from the head flit: dx > LOCAL_X → e; dx < LOCAL_X → w; otherwise dy > LOCAL_Y → n, dy < LOCAL_Y → s; otherwise c. Coordinates are compared unsigned.
- `o_output_req` is the one-hot route when `count != 0`, else all zero. The request is held unchanged until granted; the head never changes while ungranted.
- States: EMPTY (count==0), ACTIVE (0<count<DEPTH), FULL (count==DEPTH). Transitions follow the push/pop net effect. FULL forces `o_en` low.

## Timing
- Reset values: count=0, pointers=0, `o_en`=1, `o_output_req`=0, `o_overflow`=0. Data storage is not reset, so `o_data` is don't-care.
- Reset mid-operation: all buffered flits are discarded on that edge, and the next cycle looks exactly like post-reset.
- Latency: a flit pushed at edge t into an empty FIFO has its request asserted in cycle t+1.
- A grant in cycle k pops the flit at edge k. `o_data` is valid during cycle k for the crossbar.
- The next flit's request appears in cycle k+1 with no bubble. Throughput is 1 flit/cycle.
- `o_en` goes low in the cycle after the push that fills the FIFO. It returns high in the cycle after the first pop from FULL.

## Configuration
- `MESH_INPUT_UNIT_OVF_CHECK_EN` defined: port `o_overflow` exists. It is set on any edge where `i_data_val && !o_en`, or where `i_grant && count==0`, and holds until `reset`.
- Macro not defined: the port is absent and those events are silently ignored. Datapath behaviour is identical either way.

## Test plan
- Reset → `o_en`=1, `o_output_req`=5'b00000. Then push one flit with dest (2,0) at LOCAL (1,1) → next cycle `o_output_req`=e (5'b00100), `o_data`= that flit.
- Routing sweep at LOCAL (1,1): dests (0,3), (1,2), (1,0), (1,1) → w, n, s, c (5'b00001, 01000, 00010, 10000).
- DEPTH=4 with no grants: push 4 → `o_en` low in the following cycle. A 5th valid is dropped; granting 4 times yields the original 4 flits in order.
- Continuous push plus continuous grant for 10 cycles → 1 flit/cycle out, count stays 1, pointers wrap twice, no loss.
- Fill 3 flits, assert `reset` for one cycle with `i_grant` high → next cycle count 0, `o_en`=1, request 0.
- With the macro defined: valid while full, then grant while empty → `o_overflow` rises after the first event and stays 1 until reset. Without the macro, the same stimulus leaves the FIFO contents unchanged and intact.

Source files
------------

// File: rtl/mesh_input_unit.sv
// Per-port input buffer for a MESH router: flit FIFO, XY route of the head flit, one-hot output request.
// Optional sticky overflow/underflow flag when MESH_INPUT_UNIT_OVF_CHECK_EN is defined.
module mesh_input_unit #(
    parameter int DATA_W  = 32,
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0,
    parameter int DEPTH   = 4,
    parameter int M       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_val,
    output logic              o_en,
    output logic [0:M-1]      o_output_req,
    input  logic              i_grant,
    output logic [DATA_W-1:0] o_data
`ifdef MESH_INPUT_UNIT_OVF_CHECK_EN
    ,
    output logic              o_overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [X_W-1:0] LX = X_W'(LOCAL_X);
    localparam logic [Y_W-1:0] LY = Y_W'(LOCAL_Y);
    localparam int P_C = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_S = 3;
    localparam int P_W = 4;

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count, count_nxt;
    logic              push, pop;
    logic [X_W-1:0]    head_x;
    logic [Y_W-1:0]    head_y;

    // X is resolved before Y, so a flit only turns north/south once its column matches.
    function automatic logic [0:M-1] route(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
        logic [0:M-1] r;
        r = '0;
        if (dx > LX)      r[P_E] = 1'b1;
        else if (dx < LX) r[P_W] = 1'b1;
        else if (dy > LY) r[P_N] = 1'b1;
        else if (dy < LY) r[P_S] = 1'b1;
        else              r[P_C] = 1'b1;
        return r;
    endfunction

    // Enable depends on registered state only, keeping grant off the upstream flow-control path.
    assign o_en   = (state != FULL);
    assign push   = i_data_val && o_en;
    assign pop    = i_grant && (state != EMPTY);
    assign o_data = mem[rd_ptr];
    assign head_x = o_data[DATA_W-1 -: X_W];
    assign head_y = o_data[DATA_W-1-X_W -: Y_W];

    always_comb begin
        count_nxt    = count;
        state_nxt    = state;
        o_output_req = '0;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        if (count_nxt == '0)            state_nxt = EMPTY;
        else if (count_nxt == FULL_CNT) state_nxt = FULL;
        else                            state_nxt = ACTIVE;
        if (state != EMPTY)
            o_output_req = route(head_x, head_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

`ifdef MESH_INPUT_UNIT_OVF_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            o_overflow <= 1'b0;
        else if ((i_data_val && !o_en) || (i_grant && (count == '0)))
            o_overflow <= 1'b1;
    end
`endif

endmodule
